// File: rtl/edf_port_tx.sv
// Egress stage behind the per-port EDF queue: pops the earliest-deadline pointer,
// bursts that packet out of the data RAM and re-frames it onto the tx interface.
module edf_port_tx #(
    parameter int PTR_LAT    = 2,
    parameter int IFG_CYCLES = 12,
    parameter int LEN_WIDTH  = 12
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tx_pause,
    input  logic        ptr_fifo_empty,
    output logic        ptr_fifo_rd,
    input  logic [15:0] ptr_fifo_dout,
    output logic        data_fifo_rd,
    input  logic [7:0]  data_fifo_dout,
    output logic        tx_sof,
    output logic        tx_dv,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        zero_len_err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PTR_WAIT = 3'd1;
    localparam logic [2:0] READ     = 3'd2;
    localparam logic [2:0] DRAIN    = 3'd3;
    localparam logic [2:0] IFG      = 3'd4;

    localparam logic [15:0] PTR_LAST = 16'(PTR_LAT);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    logic [2:0]           state;
    logic [15:0]          wait_cnt;
    logic [LEN_WIDTH-1:0] rd_cnt;
    logic [LEN_WIDTH-1:0] len;
    logic                 sof_rd;
    logic                 sof_pipe;
    logic                 dv_pipe;
    logic                 unused_len_hi;

    assign len           = ptr_fifo_dout[LEN_WIDTH-1:0];
    assign unused_len_hi = ^ptr_fifo_dout[15:LEN_WIDTH];

    // IFG is entered on the cycle of the last tx_dv, so the IDLE cycle that
    // decides the next pop is the final gap cycle and the spacing stays minimal.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            rd_cnt       <= '0;
            ptr_fifo_rd  <= 1'b0;
            data_fifo_rd <= 1'b0;
            sof_rd       <= 1'b0;
            busy         <= 1'b0;
            frame_cnt    <= '0;
            zero_len_err <= 1'b0;
        end else begin
            ptr_fifo_rd  <= 1'b0;
            zero_len_err <= 1'b0;
            sof_rd       <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ptr_fifo_empty && !tx_pause) begin
                        ptr_fifo_rd <= 1'b1;
                        wait_cnt    <= '0;
                        busy        <= 1'b1;
                        state       <= PTR_WAIT;
                    end
                end
                PTR_WAIT: begin
                    if (wait_cnt == PTR_LAST) begin
                        if (len == '0) begin
                            zero_len_err <= 1'b1;
                            wait_cnt     <= '0;
                            if (IFG_CYCLES == 0) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= IFG;
                            end
                        end else begin
                            rd_cnt       <= len;
                            data_fifo_rd <= 1'b1;
                            sof_rd       <= 1'b1;
                            state        <= READ;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                READ: begin
                    if (rd_cnt == LEN_WIDTH'(1)) begin
                        data_fifo_rd <= 1'b0;
                        state        <= DRAIN;
                    end else begin
                        rd_cnt <= rd_cnt - LEN_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    wait_cnt  <= '0;
                    if (IFG_CYCLES == 0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= IFG;
                    end
                end
                IFG: begin
                    if (wait_cnt == IFG_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM data arrives one cycle after the read and is registered once more,
    // giving the two-cycle read-to-tx latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dv_pipe  <= 1'b0;
            sof_pipe <= 1'b0;
            tx_dv    <= 1'b0;
            tx_sof   <= 1'b0;
            tx_data  <= '0;
        end else begin
            dv_pipe  <= data_fifo_rd;
            sof_pipe <= sof_rd;
            tx_dv    <= dv_pipe;
            tx_sof   <= sof_pipe;
            if (dv_pipe) begin
                tx_data <= data_fifo_dout;
            end
        end
    end

endmodule

// File: tb/tb_edf_port_tx.sv
// Bench for edf_port_tx: models the pointer FIFO and data RAM of the queue and
// checks the transmitted byte stream, framing, burst lengths, gaps and counters.
module tb_edf_port_tx;

    localparam int PTR_LAT    = 2;
    localparam int IFG_CYCLES = 12;

    typedef struct {
        int         len;
        logic [7:0] base;
        bit         rand_bytes;
        int         exp_frames;
        int         exp_zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tx_pause;
    logic        ptr_fifo_empty;
    logic        ptr_fifo_rd;
    logic [15:0] ptr_fifo_dout;
    logic        data_fifo_rd;
    logic [7:0]  data_fifo_dout;
    logic        tx_sof;
    logic        tx_dv;
    logic [7:0]  tx_data;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        zero_len_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         plen_q[$];
    logic [7:0] pend_bytes[$];
    logic [7:0] exp_bytes[$];
    int         exp_len[$];

    int ptr_dly      = -1;
    int ptr_len_hold = 0;
    bit rd_prev      = 1'b0;
    bit in_frame     = 1'b0;
    int cur_len      = 0;
    int rd_run       = 0;
    int last_run     = 0;
    int frames_model = 0;
    int zero_seen    = 0;
    int pops         = 0;
    int last_dv_cyc  = -1;
    int last_pop_cyc = 0;
    int last_gap     = 0;
    int zero_cyc     = 0;
    int rd_cycles    = 0;

    edf_port_tx #(
        .PTR_LAT   (PTR_LAT),
        .IFG_CYCLES(IFG_CYCLES),
        .LEN_WIDTH (12)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .tx_pause      (tx_pause),
        .ptr_fifo_empty(ptr_fifo_empty),
        .ptr_fifo_rd   (ptr_fifo_rd),
        .ptr_fifo_dout (ptr_fifo_dout),
        .data_fifo_rd  (data_fifo_rd),
        .data_fifo_dout(data_fifo_dout),
        .tx_sof        (tx_sof),
        .tx_dv         (tx_dv),
        .tx_data       (tx_data),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .zero_len_err  (zero_len_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply_stimulus(input int len, input logic [7:0] base, input bit rnd);
        logic [7:0] b;
        plen_q.push_back(len);
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : 8'(int'(base) + i);
            pend_bytes.push_back(b);
            exp_bytes.push_back(b);
        end
        if (len > 0) exp_len.push_back(len);
        ptr_fifo_empty = 1'b0;
    endtask

    task automatic clear_model();
        plen_q.delete();
        pend_bytes.delete();
        exp_bytes.delete();
        exp_len.delete();
        in_frame       = 1'b0;
        cur_len        = 0;
        rd_run         = 0;
        rd_prev        = 1'b0;
        ptr_dly        = -1;
        frames_model   = 0;
        last_dv_cyc    = -1;
        ptr_fifo_empty = 1'b1;
    endtask

    // One clock: observe the DUT just after the edge, then update the queue model.
    task automatic tick();
        bit pause_at_edge;
        bit empty_at_edge;
        int expv;
        pause_at_edge = tx_pause;
        empty_at_edge = ptr_fifo_empty;
        @(posedge clk);
        #1;
        cyc++;
        if (ptr_fifo_rd) begin
            pops++;
            check_output("pop_guard", {30'd0, pause_at_edge, empty_at_edge}, 32'd0);
            if (last_dv_cyc >= 0) begin
                last_gap = cyc - last_dv_cyc;
                check_output("ifg_min", {31'd0, last_gap >= IFG_CYCLES + 1}, 32'd1);
            end
            last_pop_cyc = cyc;
        end
        if (zero_len_err) begin
            zero_seen++;
            zero_cyc = cyc;
        end
        if (data_fifo_rd) begin
            rd_run++;
            rd_cycles++;
        end else if (rd_run > 0) begin
            last_run = rd_run;
            rd_run   = 0;
        end
        check_output("sof_without_dv", {31'd0, tx_sof & ~tx_dv}, 32'd0);
        if (tx_dv) begin
            check_output("frame_open", {31'd0, in_frame | tx_sof}, 32'd1);
            if (tx_sof) begin
                check_output("sof_in_frame", {31'd0, in_frame}, 32'd0);
                in_frame = 1'b1;
                cur_len  = 0;
            end
            expv = (exp_bytes.size() > 0) ? int'(exp_bytes.pop_front()) : 32'h100;
            check_output("tx_data", {24'd0, tx_data}, expv);
            cur_len++;
            last_dv_cyc = cyc;
        end else if (in_frame) begin
            in_frame = 1'b0;
            frames_model++;
            expv = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
            check_output("frame_len", cur_len, expv);
            check_output("burst_len", last_run, expv);
            check_output("frame_cnt", {16'd0, frame_cnt}, {16'd0, frames_model[15:0]});
        end
        if (rd_prev) begin
            data_fifo_dout = (pend_bytes.size() > 0) ? pend_bytes.pop_front() : 8'hEE;
        end else begin
            data_fifo_dout = 8'($urandom);
        end
        rd_prev = data_fifo_rd;
        if (ptr_fifo_rd) begin
            ptr_len_hold   = (plen_q.size() > 0) ? plen_q.pop_front() : 0;
            ptr_dly        = PTR_LAT;
            ptr_fifo_empty = (plen_q.size() == 0);
        end
        if (ptr_dly > 0) begin
            ptr_fifo_dout = 16'($urandom);
            ptr_dly--;
        end else if (ptr_dly == 0) begin
            ptr_fifo_dout = {4'($urandom), 12'(ptr_len_hold)};
            ptr_dly       = -1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        tick();
        while ((plen_q.size() != 0 || busy || in_frame) && n < budget) begin
            tick();
            n++;
        end
        check_output("idle_timeout", {31'd0, n < budget}, 32'd1);
    endtask

    initial begin
        vec_t vecs[7];
        int   exp_total;
        int   f0, z0, p0, r0, n, rel, pushed, nz, zz, len;

        vecs[0] = '{5,    8'h11, 1'b0, 1, 0};
        vecs[1] = '{1,    8'hA0, 1'b0, 1, 0};
        vecs[2] = '{0,    8'h00, 1'b0, 0, 1};
        vecs[3] = '{2,    8'hFE, 1'b0, 1, 0};
        vecs[4] = '{64,   8'h00, 1'b1, 1, 0};
        vecs[5] = '{4095, 8'h00, 1'b1, 1, 0};
        vecs[6] = '{17,   8'h40, 1'b0, 1, 0};

        rstn           = 1'b0;
        tx_pause       = 1'b0;
        ptr_fifo_empty = 1'b1;
        ptr_fifo_dout  = '0;
        data_fifo_dout = '0;
        exp_total      = 0;

        repeat (3) tick();
        check_output("rst_ptr_rd",   {31'd0, ptr_fifo_rd},  32'd0);
        check_output("rst_data_rd",  {31'd0, data_fifo_rd}, 32'd0);
        check_output("rst_tx_dv",    {31'd0, tx_dv},        32'd0);
        check_output("rst_tx_sof",   {31'd0, tx_sof},       32'd0);
        check_output("rst_tx_data",  {24'd0, tx_data},      32'd0);
        check_output("rst_busy",     {31'd0, busy},         32'd0);
        check_output("rst_frame_cnt",{16'd0, frame_cnt},    32'd0);
        check_output("rst_zero_err", {31'd0, zero_len_err}, 32'd0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            f0 = frames_model;
            z0 = zero_seen;
            p0 = pops;
            apply_stimulus(vecs[i].len, vecs[i].base, vecs[i].rand_bytes);
            wait_idle(6000);
            exp_total += vecs[i].exp_frames;
            check_output("vec_pops",      pops - p0,          32'd1);
            check_output("vec_frames",    frames_model - f0,  vecs[i].exp_frames);
            check_output("vec_zero",      zero_seen - z0,     vecs[i].exp_zero);
            check_output("vec_frame_cnt", {16'd0, frame_cnt}, exp_total);
        end

        apply_stimulus(3, 8'h21, 1'b0);
        apply_stimulus(64, 8'h00, 1'b1);
        wait_idle(2000);
        exp_total += 2;
        check_output("b2b_gap",       last_gap,           IFG_CYCLES + 1);
        check_output("b2b_frame_cnt", {16'd0, frame_cnt}, exp_total);

        tx_pause = 1'b1;
        p0 = pops;
        apply_stimulus(64, 8'h00, 1'b1);
        repeat (50) tick();
        check_output("pause_no_pop", pops - p0, 32'd0);
        tx_pause = 1'b0;
        rel = cyc;
        n = 0;
        while (pops == p0 && n < 20) begin
            tick();
            n++;
        end
        check_output("pause_release_pop", last_pop_cyc - rel, 32'd1);
        n = 0;
        while (!data_fifo_rd && n < 20) begin
            tick();
            n++;
        end
        repeat (10) tick();
        tx_pause = 1'b1;
        wait_idle(500);
        tx_pause = 1'b0;
        exp_total += 1;
        check_output("pause_frame_cnt", {16'd0, frame_cnt}, exp_total);

        z0 = zero_seen;
        p0 = pops;
        r0 = rd_cycles;
        f0 = frames_model;
        apply_stimulus(0, 8'h00, 1'b0);
        apply_stimulus(6, 8'h30, 1'b0);
        n = 0;
        while (pops < p0 + 2 && n < 200) begin
            tick();
            n++;
        end
        check_output("zero_pulse",   zero_seen - z0,     32'd1);
        check_output("zero_no_read", rd_cycles - r0,     32'd0);
        check_output("zero_no_tx",   frames_model - f0,  32'd0);
        check_output("zero_ifg",     {31'd0, (last_pop_cyc - zero_cyc >= IFG_CYCLES + 1) &&
                                             (last_pop_cyc - zero_cyc <= IFG_CYCLES + 2)}, 32'd1);
        wait_idle(500);
        exp_total += 1;
        check_output("zero_frame_cnt", {16'd0, frame_cnt}, exp_total);

        apply_stimulus(40, 8'h60, 1'b0);
        n = 0;
        while (!(in_frame && cur_len == 10) && n < 200) begin
            tick();
            n++;
        end
        check_output("reach_byte10", {31'd0, data_fifo_rd}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_output("arst_ptr_rd",    {31'd0, ptr_fifo_rd},  32'd0);
        check_output("arst_data_rd",   {31'd0, data_fifo_rd}, 32'd0);
        check_output("arst_tx_dv",     {31'd0, tx_dv},        32'd0);
        check_output("arst_tx_sof",    {31'd0, tx_sof},       32'd0);
        check_output("arst_busy",      {31'd0, busy},         32'd0);
        check_output("arst_frame_cnt", {16'd0, frame_cnt},    32'd0);
        clear_model();
        exp_total = 0;
        repeat (2) tick();
        rstn = 1'b1;
        apply_stimulus(20, 8'h80, 1'b0);
        wait_idle(500);
        exp_total = 1;
        check_output("post_rst_frame_cnt", {16'd0, frame_cnt}, exp_total);

        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        tick();
        check_output("preload_cnt", {16'd0, frame_cnt}, 32'h0000FFFF);
        frames_model = 65535;
        apply_stimulus(3, 8'h05, 1'b0);
        wait_idle(500);
        check_output("wrap_cnt", {16'd0, frame_cnt}, 32'd0);

        // Random traffic with random pause against the queue model.
        f0 = frames_model;
        z0 = zero_seen;
        pushed = 0;
        nz = 0;
        zz = 0;
        for (int c = 0; c < 4000 && pushed < 16; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                len = (($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 40)));
                apply_stimulus(len, 8'h00, 1'b1);
                pushed++;
                if (len == 0) zz++;
                else nz++;
            end
            tx_pause = ($urandom_range(0, 5) == 0);
            tick();
        end
        tx_pause = 1'b0;
        wait_idle(4000);
        check_output("rand_pushed", pushed,            32'd16);
        check_output("rand_frames", frames_model - f0, nz);
        check_output("rand_zero",   zero_seen - z0,    zz);
        check_output("rand_cnt",    {16'd0, frame_cnt}, {16'd0, 16'(nz)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
